vrased_region_monitor: RTL and testbench
========================================

// Module: vrased_region_monitor
// PURPOSE
// - Parametrised successor to the single-SMEM security monitor. Guards N_REGIONS independent trusted code
//   regions, each with its own key region, from one instance.
// - Enforces per region: entry only at the region base, exit only from the region's last instruction, no irq
//   while executing inside, key readable only from its owner region, no DMA to any key, and no DMA while any
//   region executes.
// - On a violation: latches cause and region, counts the event, and holds a reset request until the core reaches
//   RESET_HANDLER. Sits beside the openMSP430 core and replaces the OR-tree of per-property monitors.
// PARAMETERS
// - N_REGIONS      default 2                     number of protected code/key region pairs (1..8)
// - RIDX_W         default 3                     width of region index output (>= clog2(N_REGIONS), min 1)
// - REGION_BASE    default {16'hC000,16'hA000}   packed N_REGIONS*16; code base = sole legal entry; region i = bits [16i+15:16i]
// - REGION_SIZE    default {16'h1000,16'h2000}   packed N_REGIONS*16; code size in bytes, even; last instr = BASE+SIZE-2
// - KEY_BASE       default {16'h6A40,16'h6A00}   packed N_REGIONS*16; key region base
// - KEY_SIZE       default {16'h0040,16'h0040}   packed N_REGIONS*16; key region size in bytes
// - RESET_HANDLER  default 16'h0000              pc value that releases the reset request
// - RESET_HOLD     default 4                     minimum cycles reset_req stays high (>= 1)
// PORTS
// - clk         in   1       system clock
// - reset       in   1       asynchronous active-high reset
// - pc          in   16      current program counter
// - data_en     in   1       CPU data access strobe
// - data_wr     in   1       CPU data write (qualifies data_en)
// - data_addr   in   16      CPU data address
// - dma_en      in   1       DMA access strobe
// - dma_addr    in   16      DMA address
// - irq         in   1       interrupt taken this cycle
// - reset_req   out  1       registered reset request to the core (PUC)
// - viol_cause  out  3       cause of the latched violation (codes below)
// - viol_region out  RIDX_W  region index of the latched violation
// - viol_count  out  8       saturating count of violations since reset
// - in_region   out  N_REGIONS  one-hot: region i is in the EXEC state
// BEHAVIOUR
// - Reset values: reset_req=0, viol_cause=0, viol_region=0, viol_count=0, in_region=0; all region FSMs IDLE;
//   pc_prev=RESET_HANDLER.
// - Region i "hit" means BASE_i <= x < BASE_i+SIZE_i. All comparisons are 17-bit, so BASE+SIZE = 16'h0000
//   wrap is treated as 17'h10000.
// - pc_prev is registered every cycle.
// - Per-region FSM states: IDLE, EXEC, KILL.
//   - IDLE -> EXEC when pc hits region i and pc == BASE_i.
//   - EXEC -> IDLE when pc leaves region i and pc_prev == BASE_i+SIZE_i-2.
//   - Any state -> KILL on a violation flagged against any region, so all FSMs enter KILL together.
//   - KILL -> IDLE when the release condition below holds.
// - Cause codes (evaluated combinationally each cycle):
//   - 1 ILL_ENTRY: IDLE, pc hits region, pc != BASE.
//   - 2 ILL_EXIT: EXEC, pc leaves region, pc_prev != last instr.
//   - 3 IRQ_IN: irq while EXEC.
//   - 4 KEY_CPU: data_en, data_addr hits KEY_i, pc does not hit region i (writes also 4).
//   - 5 KEY_DMA: dma_en, dma_addr hits KEY_i.
//   - 6 DMA_EXEC: dma_en while any region EXEC.
// - Simultaneous violations: lowest cause code wins; within a cause, lowest region index wins.
// - Latency: violation in cycle t -> reset_req, viol_cause, viol_region, count++ visible at edge t+1.
// - Release: reset_req stays high >= RESET_HOLD cycles AND until pc == RESET_HANDLER.
//   - It drops on the edge after both hold.
//   - viol_cause and viol_region persist until the next violation or reset.
// - Violations while any FSM is in KILL are ignored: not latched, not counted, hold timer not restarted.
// - viol_count saturates at 8'hFF; it never wraps.
// - Async reset mid-KILL or mid-EXEC: all state and outputs return to reset values immediately.
// STRUCTURE
// - vrased_mon_defines.v (shared, `define): cause codes CAUSE_NONE..CAUSE_DMA_EXEC, FSM encodings
//   ST_IDLE/ST_EXEC/ST_KILL (2-bit), 16-bit range-hit macro.
// - Sub-module vrased_region_fsm: one region's hit logic, 3-state FSM, per-cause flags; instantiated N_REGIONS
//   times via generate.
// - Top level: priority encoder, cause/region latch, hold counter (clog2(RESET_HOLD)+1 bits), saturating counter.
// TESTING
// 1. Enter region 0 at pc=A000, run to A002..BFFE, exit to 1234 -> reset_req stays 0; in_region=01 then 00.
// 2. pc jumps 1234->A010 -> next edge reset_req=1, cause=1, region=0, count=1; pc=0000 after 4 cycles -> reset_req=0.
// 3. In region 1 (pc=C100), irq=1 and dma_en=1 with dma_addr=6A00 same cycle -> cause=3, region=1 (priority).
// 4. pc=1234 reads data_addr=6A44 -> cause=4, region=1; a second violation during KILL -> count unchanged.
// 5. Force 300 violations with pc returning to 0000 between them -> viol_count=FF, no wrap.
// 6. Assert reset while reset_req=1 and hold counter=2 -> all outputs 0 asynchronously; release reset, pc=A000 -> in_region=01.

Source files
------------

// File: rtl/vrased_region_monitor_pkg.sv
// Shared definitions for the multi-region security monitor: violation cause
// codes, per-region FSM state encoding and the 17-bit address range check.
package vrased_region_monitor_pkg;

  typedef enum logic [2:0] {
    CAUSE_NONE      = 3'd0,
    CAUSE_ILL_ENTRY = 3'd1,
    CAUSE_ILL_EXIT  = 3'd2,
    CAUSE_IRQ_IN    = 3'd3,
    CAUSE_KEY_CPU   = 3'd4,
    CAUSE_KEY_DMA   = 3'd5,
    CAUSE_DMA_EXEC  = 3'd6
  } cause_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_KILL = 2'd2
  } state_e;

  localparam int N_CAUSES = 6;

  // base <= x < base+size, evaluated on 17 bits so a region ending exactly
  // at the top of the address space (base+size == 16'h0000) still works.
  function automatic logic range_hit(input logic [15:0] x,
                                     input logic [15:0] base,
                                     input logic [15:0] size);
    logic [16:0] lo;
    logic [16:0] hi;
    logic [16:0] xv;
    lo = {1'b0, base};
    hi = lo + {1'b0, size};
    xv = {1'b0, x};
    return (xv >= lo) && (xv < hi);
  endfunction

endpackage

// File: rtl/vrased_region_monitor_fsm.sv
// One protected code/key region: hit logic, IDLE/EXEC/KILL state machine and
// the per-cause violation flags raised against this region.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   pc, pc_prev         current and previous program counter
//   data_en, data_addr  CPU data access
//   dma_en, dma_addr    DMA access
//   irq                 interrupt taken this cycle
//   kill                a violation was accepted this cycle (all regions)
//   release_kill        the reset request is being released this cycle
//   exec                region is in EXEC
//   killed              region is in KILL
//   flags               violation flags, bit index == cause code
module vrased_region_monitor_fsm
  import vrased_region_monitor_pkg::*;
#(
  parameter logic [15:0] BASE     = 16'hA000,
  parameter logic [15:0] SIZE     = 16'h2000,
  parameter logic [15:0] KEY_BASE = 16'h6A00,
  parameter logic [15:0] KEY_SIZE = 16'h0040
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         pc,
  input  logic [15:0]         pc_prev,
  input  logic                data_en,
  input  logic [15:0]         data_addr,
  input  logic                dma_en,
  input  logic [15:0]         dma_addr,
  input  logic                irq,
  input  logic                kill,
  input  logic                release_kill,
  output logic                exec,
  output logic                killed,
  output logic [N_CAUSES:1]   flags
);

  localparam logic [15:0] LAST = BASE + SIZE - 16'd2;

  state_e state;
  logic   pc_hit;

  assign pc_hit = range_hit(pc, BASE, SIZE);
  assign exec   = (state == ST_EXEC);
  assign killed = (state == ST_KILL);

  always_comb begin
    flags = '0;
    flags[CAUSE_ILL_ENTRY] = (state == ST_IDLE) && pc_hit && (pc != BASE);
    flags[CAUSE_ILL_EXIT]  = (state == ST_EXEC) && !pc_hit && (pc_prev != LAST);
    flags[CAUSE_IRQ_IN]    = (state == ST_EXEC) && irq;
    // Reads and writes are treated alike: any touch from outside the owner.
    flags[CAUSE_KEY_CPU]   = data_en && range_hit(data_addr, KEY_BASE, KEY_SIZE) && !pc_hit;
    flags[CAUSE_KEY_DMA]   = dma_en && range_hit(dma_addr, KEY_BASE, KEY_SIZE);
    flags[CAUSE_DMA_EXEC]  = dma_en && (state == ST_EXEC);
  end

  // A violation anywhere overrides the normal transitions of every region.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (kill) begin
      state <= ST_KILL;
    end else begin
      case (state)
        ST_IDLE: if (pc == BASE) state <= ST_EXEC;
        ST_EXEC: if (!pc_hit && (pc_prev == LAST)) state <= ST_IDLE;
        ST_KILL: if (release_kill) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/vrased_region_monitor.sv
// Multi-region security monitor. Guards N_REGIONS trusted code regions and
// their keys; on a violation it latches cause/region, counts the event and
// holds reset_req until the core has reached RESET_HANDLER.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   pc                    current program counter
//   data_en/wr/addr       CPU data access
//   dma_en, dma_addr      DMA access
//   irq                   interrupt taken this cycle
//   reset_req             registered reset request to the core
//   viol_cause            cause code of the last latched violation
//   viol_region           region index of the last latched violation
//   viol_count            saturating violation count
//   in_region             bit i set while region i is executing
module vrased_region_monitor
  import vrased_region_monitor_pkg::*;
#(
  parameter int                        N_REGIONS     = 2,
  parameter int                        RIDX_W        = 3,
  parameter logic [N_REGIONS*16-1:0]   REGION_BASE   = {16'hC000, 16'hA000},
  parameter logic [N_REGIONS*16-1:0]   REGION_SIZE   = {16'h1000, 16'h2000},
  parameter logic [N_REGIONS*16-1:0]   KEY_BASE      = {16'h6A40, 16'h6A00},
  parameter logic [N_REGIONS*16-1:0]   KEY_SIZE      = {16'h0040, 16'h0040},
  parameter logic [15:0]               RESET_HANDLER = 16'h0000,
  parameter int                        RESET_HOLD    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           pc,
  input  logic                  data_en,
  input  logic                  data_wr,
  input  logic [15:0]           data_addr,
  input  logic                  dma_en,
  input  logic [15:0]           dma_addr,
  input  logic                  irq,
  output logic                  reset_req,
  output logic [2:0]            viol_cause,
  output logic [RIDX_W-1:0]     viol_region,
  output logic [7:0]            viol_count,
  output logic [N_REGIONS-1:0]  in_region
);

  localparam int HOLD_W = $clog2(RESET_HOLD) + 1;

  logic [15:0]          pc_prev;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [N_CAUSES:1]    flags [N_REGIONS];
  logic [N_REGIONS-1:0] kill_vec;
  logic                 any_kill;
  logic                 any_flag;
  logic                 viol;
  logic                 release_kill;
  logic [2:0]           sel_cause;
  logic [RIDX_W-1:0]    sel_region;
  logic                 unused_data_wr;

  assign unused_data_wr = data_wr;

  for (genvar g = 0; g < N_REGIONS; g++) begin : g_region
    vrased_region_monitor_fsm #(
      .BASE     (REGION_BASE[16*g +: 16]),
      .SIZE     (REGION_SIZE[16*g +: 16]),
      .KEY_BASE (KEY_BASE[16*g +: 16]),
      .KEY_SIZE (KEY_SIZE[16*g +: 16])
    ) u_fsm (
      .clk          (clk),
      .reset        (reset),
      .pc           (pc),
      .pc_prev      (pc_prev),
      .data_en      (data_en),
      .data_addr    (data_addr),
      .dma_en       (dma_en),
      .dma_addr     (dma_addr),
      .irq          (irq),
      .kill         (viol),
      .release_kill (release_kill),
      .exec         (in_region[g]),
      .killed       (kill_vec[g]),
      .flags        (flags[g])
    );
  end

  // Scan from the highest cause/region down so the lowest one found last wins.
  always_comb begin
    sel_cause  = CAUSE_NONE;
    sel_region = '0;
    any_flag   = 1'b0;
    for (int c = N_CAUSES; c >= 1; c--) begin
      for (int i = N_REGIONS - 1; i >= 0; i--) begin
        if (flags[i][c]) begin
          sel_cause  = 3'(c);
          sel_region = RIDX_W'(i);
          any_flag   = 1'b1;
        end
      end
    end
  end

  assign any_kill     = |kill_vec;
  assign viol         = any_flag && !any_kill;
  assign release_kill = reset_req && (hold_cnt == '0) && (pc == RESET_HANDLER);

  // hold_cnt is loaded with RESET_HOLD-1 so that it reads zero in the
  // RESET_HOLD-th cycle that reset_req is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_prev     <= RESET_HANDLER;
      reset_req   <= 1'b0;
      viol_cause  <= CAUSE_NONE;
      viol_region <= '0;
      viol_count  <= '0;
      hold_cnt    <= '0;
    end else begin
      pc_prev <= pc;
      if (viol) begin
        reset_req   <= 1'b1;
        viol_cause  <= sel_cause;
        viol_region <= sel_region;
        hold_cnt    <= HOLD_W'(RESET_HOLD - 1);
        if (viol_count != 8'hFF) viol_count <= viol_count + 8'd1;
      end else if (reset_req) begin
        if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
        else if (pc == RESET_HANDLER) reset_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vrased_region_monitor.sv
module tb_vrased_region_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc = 16'h0000;
  logic        data_en = 1'b0;
  logic        data_wr = 1'b0;
  logic [15:0] data_addr = 16'h0000;
  logic        dma_en = 1'b0;
  logic [15:0] dma_addr = 16'h0000;
  logic        irq = 1'b0;
  logic        reset_req;
  logic [2:0]  viol_cause;
  logic [2:0]  viol_region;
  logic [7:0]  viol_count;
  logic [1:0]  in_region;

  vrased_region_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .data_en     (data_en),
    .data_wr     (data_wr),
    .data_addr   (data_addr),
    .dma_en      (dma_en),
    .dma_addr    (dma_addr),
    .irq         (irq),
    .reset_req   (reset_req),
    .viol_cause  (viol_cause),
    .viol_region (viol_region),
    .viol_count  (viol_count),
    .in_region   (in_region)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rr;
    logic [2:0] cause;
    logic [2:0] region;
    logic [7:0] cnt;
    logic [1:0] inr;
  } exp_t;

  exp_t q[$];

  // Reference model: regions described by plain integer ranges.
  int rb[2] = '{32'hA000, 32'hC000};
  int rs[2] = '{32'h2000, 32'h1000};
  int kb[2] = '{32'h6A00, 32'h6A40};
  int ks[2] = '{32'h0040, 32'h0040};
  localparam int HOLD = 4;
  localparam int HANDLER = 0;

  bit m_exec[2];
  bit m_kill;
  int m_age, m_cnt, m_cause, m_region, m_pcp;

  function automatic bit in_rng(int x, int b, int s);
    return (x >= b) && (x < b + s);
  endfunction

  function void model_reset();
    m_exec = '{0, 0};
    m_kill = 0; m_age = 0; m_cnt = 0; m_cause = 0; m_region = 0;
    m_pcp = HANDLER;
  endfunction

  function automatic bit rule(int c, int r, int p, bit den, int da, bit men, int ma, bit ir);
    bit h;
    h = in_rng(p, rb[r], rs[r]);
    case (c)
      1: return !m_exec[r] && h && p != rb[r];
      2: return m_exec[r] && !h && m_pcp != rb[r] + rs[r] - 2;
      3: return m_exec[r] && ir;
      4: return den && in_rng(da, kb[r], ks[r]) && !h;
      5: return men && in_rng(ma, kb[r], ks[r]);
      6: return men && m_exec[r];
      default: return 0;
    endcase
  endfunction

  function void model_step(int p, bit den, int da, bit men, int ma, bit ir);
    bit found;
    int fc, fr;
    found = 0; fc = 0; fr = 0;
    for (int c = 1; c <= 6; c++)
      for (int r = 0; r < 2; r++)
        if (!found && rule(c, r, p, den, da, men, ma, ir)) begin
          found = 1; fc = c; fr = r;
        end
    if (m_kill) begin
      m_age++;
      if (m_age >= HOLD && p == HANDLER) m_kill = 0;
    end else if (found) begin
      m_kill = 1; m_age = 0;
      m_exec = '{0, 0};
      m_cause = fc; m_region = fr;
      if (m_cnt < 255) m_cnt++;
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (!m_exec[r] && p == rb[r]) m_exec[r] = 1;
        else if (m_exec[r] && !in_rng(p, rb[r], rs[r]) && m_pcp == rb[r] + rs[r] - 2)
          m_exec[r] = 0;
      end
    end
    m_pcp = p;
  endfunction

  task automatic cyc(input logic [15:0] p, input logic den = 0, input logic [15:0] da = 0,
                     input logic men = 0, input logic [15:0] ma = 0, input logic ir = 0);
    exp_t e;
    pc = p; data_en = den; data_wr = 1'($urandom_range(0, 1)); data_addr = da;
    dma_en = men; dma_addr = ma; irq = ir;
    model_step(int'(p), den, int'(da), men, int'(ma), ir);
    e.rr = m_kill; e.cause = 3'(m_cause); e.region = 3'(m_region);
    e.cnt = 8'(m_cnt); e.inr = {m_exec[1], m_exec[0]};
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs after each active edge against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (reset_req !== e.rr || viol_cause !== e.cause || viol_region !== e.region ||
            viol_count !== e.cnt || in_region !== e.inr) begin
          errors++;
          $display("FAIL outputs @%0t: got rr=%0b cause=%0d reg=%0d cnt=%0h inr=%b expected rr=%0b cause=%0d reg=%0d cnt=%0h inr=%b",
                   $time, reset_req, viol_cause, viol_region, viol_count, in_region,
                   e.rr, e.cause, e.region, e.cnt, e.inr);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  function automatic logic [15:0] rand_pc();
    case ($urandom_range(0, 10))
      0: return 16'hA000;
      1: return 16'hC000;
      2: return 16'hA000 + 16'({$urandom_range(0, 16'h0FFF), 1'b0});
      3: return 16'hC000 + 16'({$urandom_range(0, 16'h07FF), 1'b0});
      4: return 16'hBFFE;
      5: return 16'hCFFE;
      6, 7: return 16'h0000;
      8: return 16'h1234;
      9: return pc + 16'd2;
      default: return 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFE;
    endcase
  endfunction

  initial begin
    model_reset();
    @(negedge clk);
    chk("reset_req@reset", int'(reset_req), 0);
    chk("cause@reset", int'(viol_cause), 0);
    chk("region@reset", int'(viol_region), 0);
    chk("count@reset", int'(viol_count), 0);
    chk("in_region@reset", int'(in_region), 0);
    reset = 1'b0;
    cyc(16'h0000);
    cyc(16'h0000);

    // Legal pass through region 0
    cyc(16'hA000);
    for (int a = 'hA002; a <= 'hBFFE; a += 2) cyc(16'(a));
    cyc(16'h1234);
    cyc(16'h1234);

    // Illegal entry, then release after hold
    cyc(16'hA010);
    for (int k = 0; k < 5; k++) cyc(16'h0000);

    // irq + DMA inside region 1: irq has priority
    cyc(16'hC000);
    cyc(16'hC100);
    cyc(16'hC100, 0, 0, 1, 16'h6A00, 1);
    for (int k = 0; k < 5; k++) cyc(16'h0000);

    // Key of region 1 read from outside, then ignored violation during KILL
    cyc(16'h1234, 1, 16'h6A44);
    cyc(16'hA010);
    for (int k = 0; k < 5; k++) cyc(16'h0000);

    // Counter saturation
    for (int v = 0; v < 300; v++) begin
      cyc(16'hA010);
      for (int k = 0; k < 4; k++) cyc(16'h0000);
    end
    cyc(16'h0000);

    // Randomised traffic
    for (int n = 0; n < 2000; n++) begin
      logic den, men, ir;
      den = ($urandom_range(0, 7) == 0);
      men = ($urandom_range(0, 15) == 0);
      ir  = ($urandom_range(0, 15) == 0);
      cyc(rand_pc(), den, 16'($urandom_range(16'h69F0, 16'h6A90)),
          men, 16'($urandom_range(16'h69F0, 16'h6A90)), ir);
    end
    for (int k = 0; k < 8; k++) cyc(16'h0000);

    // Async reset two cycles into KILL
    cyc(16'hA010);
    cyc(16'h0000);
    reset = 1'b1;
    #1;
    chk("reset_req@async", int'(reset_req), 0);
    chk("cause@async", int'(viol_cause), 0);
    chk("region@async", int'(viol_region), 0);
    chk("count@async", int'(viol_count), 0);
    chk("in_region@async", int'(in_region), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cyc(16'hA000);
    cyc(16'hA002);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
